// File: rtl/tlb_op_ctrl.sv
// Sequencer for TLBP/TLBR/TLBWI/TLBWR retiring in WB: drives TLB search/read/write
// ports, issues CP0 update strobes, requests refetch and maintains CP0 Random.
module tlb_op_ctrl #(
   parameter int TLBNUM = 16,
   parameter int IDX_W  = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             op_valid,
   input  logic [1:0]       op_type,
   input  logic [31:0]      op_pc,
   output logic             op_ready,
   input  logic             flush,
   output logic             busy,
   input  logic [18:0]      c0_vpn2,
   input  logic [7:0]       c0_asid,
   input  logic [IDX_W-1:0] c0_index,
   input  logic [IDX_W-1:0] c0_wired,
   output logic [18:0]      s_vpn2,
   output logic [7:0]       s_asid,
   input  logic             s_found,
   input  logic [IDX_W-1:0] s_index,
   output logic             tlbp_wen,
   output logic             tlbp_found,
   output logic [IDX_W-1:0] tlbp_index,
   output logic [IDX_W-1:0] r_index,
   output logic             tlbr_wen,
   output logic             we,
   output logic [IDX_W-1:0] w_index,
   output logic [IDX_W-1:0] c0_random,
   output logic             refetch_valid,
   output logic [31:0]      refetch_pc
);

   localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(TLBNUM - 1);

   localparam logic [1:0] OP_TLBP  = 2'b00;
   localparam logic [1:0] OP_TLBR  = 2'b01;
   localparam logic [1:0] OP_TLBWI = 2'b10;
   localparam logic [1:0] OP_TLBWR = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE, S_PROBE, S_PWB, S_READ, S_RWB, S_WRITE, S_REFETCH
   } state_t;

   state_t state, state_nxt;
   logic   accept;

   assign accept = op_valid && op_ready;

   // The search port is shared, so the key always follows EntryHi.
   assign s_vpn2 = c0_vpn2;
   assign s_asid = c0_asid;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  case (op_type)
                     OP_TLBP: state_nxt = S_PROBE;
                     OP_TLBR: state_nxt = S_READ;
                     default: state_nxt = S_WRITE;
                  endcase
               end
            end
            S_PROBE:   state_nxt = S_PWB;
            S_PWB:     state_nxt = S_IDLE;
            S_READ:    state_nxt = S_RWB;
            S_RWB:     state_nxt = S_REFETCH;
            S_WRITE:   state_nxt = S_REFETCH;
            S_REFETCH: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
         endcase
      end
   end

   // Strobes are pure state decodes so an async reset kills them immediately.
   always_comb begin
      op_ready      = (state == S_IDLE) && !flush;
      busy          = (state != S_IDLE);
      tlbp_wen      = (state == S_PWB)     && !flush;
      tlbr_wen      = (state == S_RWB)     && !flush;
      we            = (state == S_WRITE)   && !flush;
      refetch_valid = (state == S_REFETCH) && !flush;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tlbp_found <= 1'b0;
         tlbp_index <= '0;
      end else if (state == S_PROBE) begin
         tlbp_found <= s_found;
         tlbp_index <= s_index;
      end
   end

   // Indices and return PC are latched at accept and held through the op.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_index    <= '0;
         w_index    <= '0;
         refetch_pc <= '0;
      end else if (accept) begin
         if (op_type == OP_TLBR)  r_index <= c0_index;
         if (op_type == OP_TLBWI) w_index <= c0_index;
         if (op_type == OP_TLBWR) w_index <= c0_random;
         if (op_type != OP_TLBP)  refetch_pc <= op_pc + 32'd4;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                   c0_random <= RAND_TOP;
      else if (c0_random <= c0_wired) c0_random <= RAND_TOP;
      else                           c0_random <= c0_random - 1'b1;
   end

endmodule
